// File: rtl/riscv_mem_arbiter.sv
// Data RAM arbiter between the core load/store path and a loader/DMA port.
// Build option: MEM_ARB_RR_EN selects round-robin conflict arbitration (default: core priority).
module riscv_mem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_rd,
   input  logic          core_wr,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CORE_RD = 2'd1,
      LD_RD   = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_gnt, last_gnt_nxt;
   logic   core_req, core_win, ld_win;

   always_comb begin
      core_req = core_rd | core_wr;
`ifdef MEM_ARB_RR_EN
      // last_gnt=1 means the loader won last, so the core takes the next conflict
      core_win = core_req & (~ld_req | last_gnt);
`else
      core_win = core_req;
`endif
      ld_win = ld_req & ~core_win;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      core_rdata   = '0;
      core_stall   = 1'b0;
      ld_gnt       = 1'b0;
      ld_rvalid    = 1'b0;
      ld_rdata     = '0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state)
         IDLE: begin
            if (core_win) begin
               mem_en       = 1'b1;
               mem_we       = core_wr;
               mem_addr     = core_addr;
               mem_wdata    = core_wdata;
               core_stall   = ~core_wr;
               last_gnt_nxt = 1'b0;
               if (!core_wr) state_nxt = CORE_RD;
            end else begin
               core_stall = core_req;
               if (ld_win) begin
                  ld_gnt       = 1'b1;
                  mem_en       = 1'b1;
                  mem_we       = ld_we;
                  mem_addr     = ld_addr;
                  mem_wdata    = ld_wdata;
                  last_gnt_nxt = 1'b1;
                  if (!ld_we) state_nxt = LD_RD;
               end
            end
         end
         CORE_RD: begin
            core_rdata = mem_rdata;
            state_nxt  = IDLE;
         end
         LD_RD: begin
            ld_rvalid  = 1'b1;
            ld_rdata   = mem_rdata;
            core_stall = core_req;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // outputs are held quiet for the whole time reset is asserted
      if (rst) begin
         state_nxt    = IDLE;
         last_gnt_nxt = 1'b1;
         core_rdata   = '0;
         core_stall   = 1'b0;
         ld_gnt       = 1'b0;
         ld_rvalid    = 1'b0;
         ld_rdata     = '0;
         mem_en       = 1'b0;
         mem_we       = 1'b0;
         mem_addr     = '0;
         mem_wdata    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (core_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus randomized traffic vs a cycle model.
module tb_riscv_mem_arbiter;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        core_rd, core_wr;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_stall;
   logic        ld_req, ld_we;
   logic [31:0] ld_addr, ld_wdata, ld_rdata;
   logic        ld_gnt, ld_rvalid;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;

   logic [31:0] d2_core_rdata, d2_ld_rdata, d2_mem_addr, d2_mem_wdata;
   logic        d2_core_stall, d2_ld_gnt, d2_ld_rvalid, d2_mem_en, d2_mem_we;
   logic [1:0]  d2_stall_cnt;

   int checks = 0;
   int failures = 0;

   bit [31:0] ram [256];

   riscv_mem_arbiter #(.AW(32), .DW(32), .CW(16)) u_dut (
      .clk(clk), .rst(rst),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   riscv_mem_arbiter #(.AW(32), .DW(32), .CW(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(d2_core_rdata), .core_stall(d2_core_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(d2_ld_gnt), .ld_rvalid(d2_ld_rvalid), .ld_rdata(d2_ld_rdata),
      .mem_en(d2_mem_en), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(d2_stall_cnt)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   task automatic idle_inputs();
      core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      core_rd = 1'b1; core_wr = 1'b1; core_addr = 32'h44; core_wdata = 32'h5;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h8; ld_wdata = 32'h6;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL rst_core_stall got=%b exp=0", core_stall); end
      checks++; if (ld_gnt !== 1'b0) begin failures++; $display("FAIL rst_ld_gnt got=%b exp=0", ld_gnt); end
      checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL rst_ld_rvalid got=%b exp=0", ld_rvalid); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
      checks++; if (d2_stall_cnt !== 2'h0) begin failures++; $display("FAIL rst_stall_cnt2 got=%0d exp=0", d2_stall_cnt); end
      @(posedge clk);
      #1 rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_core_store();
      core_wr = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL st_mem_en got=%b exp=1", mem_en); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL st_mem_we got=%b exp=1", mem_we); end
      checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL st_mem_addr got=%h exp=10", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL st_mem_wdata got=%h exp=deadbeef", mem_wdata); end
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL st_core_stall got=%b exp=0", core_stall); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL st_stall_cnt got=%0d exp=0", stall_cnt); end
      next_cycle();
   endtask

   task automatic test_core_load();
      core_rd = 1'b1; core_addr = 32'h10;
      @(negedge clk);
      checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL ld0_core_stall got=%b exp=1", core_stall); end
      checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL ld0_mem_en got=%b exp=1", mem_en); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ld0_mem_we got=%b exp=0", mem_we); end
      next_cycle();
      @(negedge clk);
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL ld1_core_stall got=%b exp=0", core_stall); end
      checks++; if (core_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld1_core_rdata got=%h exp=deadbeef", core_rdata); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL ld1_mem_en got=%b exp=0", mem_en); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL ld_stall_cnt got=%0d exp=1", stall_cnt); end
      checks++; if (core_rdata !== 32'h0) begin failures++; $display("FAIL ld_rdata_idle got=%h exp=0", core_rdata); end
      next_cycle();
   endtask

   task automatic test_loader_read();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
      @(negedge clk);
      checks++; if (ld_gnt !== 1'b1) begin failures++; $display("FAIL lw_gnt got=%b exp=1", ld_gnt); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL lw_mem_we got=%b exp=1", mem_we); end
      next_cycle();
      ld_we = 1'b0;
      @(negedge clk);
      checks++; if (ld_gnt !== 1'b1) begin failures++; $display("FAIL lr_gnt got=%b exp=1", ld_gnt); end
      checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL lr_mem_en got=%b exp=1", mem_en); end
      checks++; if (mem_addr !== 32'h20) begin failures++; $display("FAIL lr_mem_addr got=%h exp=20", mem_addr); end
      next_cycle();
      ld_req = 1'b0;
      @(negedge clk);
      checks++; if (ld_rvalid !== 1'b1) begin failures++; $display("FAIL lr_rvalid got=%b exp=1", ld_rvalid); end
      checks++; if (ld_rdata !== 32'h12345678) begin failures++; $display("FAIL lr_rdata got=%h exp=12345678", ld_rdata); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL lr_mem_en_dp got=%b exp=0", mem_en); end
      next_cycle();
      @(negedge clk);
      checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL lr_rvalid_after got=%b exp=0", ld_rvalid); end
      checks++; if (ld_rdata !== 32'h0) begin failures++; $display("FAIL lr_rdata_after got=%h exp=0", ld_rdata); end
      next_cycle();
   endtask

   task automatic test_contention();
      logic exp_ld;
      do_reset();
      core_wr = 1'b1; core_addr = 32'h30; core_wdata = 32'hAAAA0001;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hBBBB0002;
      for (int i = 0; i < 4; i++) begin
         exp_ld = RR && (i % 2 == 1);
         @(negedge clk);
         checks++; if (ld_gnt !== exp_ld) begin failures++; $display("FAIL cont_ld_gnt[%0d] got=%b exp=%b", i, ld_gnt, exp_ld); end
         checks++; if (core_stall !== exp_ld) begin failures++; $display("FAIL cont_core_stall[%0d] got=%b exp=%b", i, core_stall, exp_ld); end
         checks++; if (mem_addr !== (exp_ld ? 32'h40 : 32'h30)) begin failures++; $display("FAIL cont_mem_addr[%0d] got=%h exp=%h", i, mem_addr, exp_ld ? 32'h40 : 32'h30); end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      checks++; if (stall_cnt !== (RR ? 16'd2 : 16'd0)) begin failures++; $display("FAIL cont_stall_cnt got=%0d exp=%0d", stall_cnt, RR ? 2 : 0); end
      next_cycle();
   endtask

   task automatic test_reset_inflight();
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
      @(negedge clk);
      checks++; if (ld_gnt !== 1'b1) begin failures++; $display("FAIL rif_gnt got=%b exp=1", ld_gnt); end
      next_cycle();
      ld_req = 1'b0;
      core_rd = 1'b1; core_addr = 32'h20;
      rst = 1'b1;
      #1;
      checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL rif_rvalid got=%b exp=0", ld_rvalid); end
      checks++; if (ld_rdata !== 32'h0) begin failures++; $display("FAIL rif_rdata got=%h exp=0", ld_rdata); end
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL rif_core_stall got=%b exp=0", core_stall); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rif_mem_en got=%b exp=0", mem_en); end
      next_cycle();
      rst = 1'b0;
      core_rd = 1'b0; core_wr = 1'b1; core_addr = 32'h50; core_wdata = 32'hCAFEF00D;
      @(negedge clk);
      checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL rif_rvalid_post got=%b exp=0", ld_rvalid); end
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL rif_store got=%b%b exp=11", mem_en, mem_we); end
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL rif_store_stall got=%b exp=0", core_stall); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rif_stall_cnt got=%0d exp=0", stall_cnt); end
      next_cycle();
   endtask

   task automatic test_saturation();
      int exp_cnt;
      logic p;
      do_reset();
      core_rd = 1'b1; core_addr = 32'h10;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
      exp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         // core issue / data / (RR: loader wins, loader data) pattern of stall cycles
         p = RR ? (i % 4 != 1) : (i % 2 == 0);
         @(negedge clk);
         checks++; if (core_stall !== p) begin failures++; $display("FAIL sat_stall[%0d] got=%b exp=%b", i, core_stall, p); end
         checks++; if (d2_stall_cnt !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, d2_stall_cnt, (exp_cnt > 3) ? 3 : exp_cnt); end
         @(posedge clk);
         if (p) exp_cnt++;
         #1;
      end
      idle_inputs();
      @(negedge clk);
      checks++; if (stall_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, exp_cnt); end
      checks++; if (d2_stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt2_final got=%0d exp=3", d2_stall_cnt); end
      next_cycle();
   endtask

   task automatic test_random();
      bit [31:0] mram [256];
      int        phase, phase_n, stalls, r;
      logic [7:0] paddr;
      logic      lastg, c_hold, l_hold, creq, cw, lw;
      logic      e_stall, e_gnt, e_rv, e_en, e_we;
      logic [31:0] e_addr, e_wd, e_crd, e_lrd;
      do_reset();
      for (int k = 0; k < 256; k++) mram[k] = ram[k];
      phase = 0; stalls = 0; lastg = 1'b1; c_hold = 1'b0; l_hold = 1'b0;
      cw = 1'b0; lw = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!c_hold) begin
            r = $urandom_range(3, 0);
            core_rd = (r == 1) || (r == 3);
            core_wr = (r >= 2);
            core_addr = $urandom_range(7, 0);
            core_wdata = $urandom;
         end
         if (!l_hold) begin
            ld_req = $urandom_range(1, 0);
            ld_we = $urandom_range(1, 0);
            ld_addr = $urandom_range(7, 0);
            ld_wdata = $urandom;
         end
         @(negedge clk);
         creq = core_rd | core_wr;
         e_stall = 1'b0; e_gnt = 1'b0; e_rv = 1'b0; e_en = 1'b0; e_we = 1'b0;
         e_addr = '0; e_wd = '0; e_crd = '0; e_lrd = '0; cw = 1'b0; lw = 1'b0;
         if (phase == 1) begin
            e_crd = mram[paddr];
         end else if (phase == 2) begin
            e_rv = 1'b1; e_lrd = mram[paddr]; e_stall = creq;
         end else begin
            cw = creq && (!ld_req || !RR || lastg);
            lw = ld_req && !cw;
            e_en = cw || lw;
            e_we = cw ? core_wr : (lw && ld_we);
            e_addr = cw ? core_addr : ld_addr;
            e_wd = cw ? core_wdata : ld_wdata;
            e_gnt = lw;
            e_stall = creq && !(cw && core_wr);
         end
         checks++; if (core_stall !== e_stall) begin failures++; $display("FAIL rnd_core_stall[%0d] got=%b exp=%b", n, core_stall, e_stall); end
         checks++; if (ld_gnt !== e_gnt) begin failures++; $display("FAIL rnd_ld_gnt[%0d] got=%b exp=%b", n, ld_gnt, e_gnt); end
         checks++; if (ld_rvalid !== e_rv) begin failures++; $display("FAIL rnd_ld_rvalid[%0d] got=%b exp=%b", n, ld_rvalid, e_rv); end
         checks++; if (mem_en !== e_en) begin failures++; $display("FAIL rnd_mem_en[%0d] got=%b exp=%b", n, mem_en, e_en); end
         if (e_en) begin
            checks++; if (mem_we !== e_we) begin failures++; $display("FAIL rnd_mem_we[%0d] got=%b exp=%b", n, mem_we, e_we); end
            checks++; if (mem_addr !== e_addr) begin failures++; $display("FAIL rnd_mem_addr[%0d] got=%h exp=%h", n, mem_addr, e_addr); end
            if (e_we) begin
               checks++; if (mem_wdata !== e_wd) begin failures++; $display("FAIL rnd_mem_wdata[%0d] got=%h exp=%h", n, mem_wdata, e_wd); end
            end
         end
         checks++; if (core_rdata !== e_crd) begin failures++; $display("FAIL rnd_core_rdata[%0d] got=%h exp=%h", n, core_rdata, e_crd); end
         checks++; if (ld_rdata !== e_lrd) begin failures++; $display("FAIL rnd_ld_rdata[%0d] got=%h exp=%h", n, ld_rdata, e_lrd); end
         checks++; if (stall_cnt !== 16'(stalls)) begin failures++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", n, stall_cnt, stalls); end
         checks++; if (d2_stall_cnt !== 2'((stalls > 3) ? 3 : stalls)) begin failures++; $display("FAIL rnd_stall_cnt2[%0d] got=%0d exp=%0d", n, d2_stall_cnt, (stalls > 3) ? 3 : stalls); end
         @(posedge clk);
         if (e_stall) stalls++;
         c_hold = e_stall;
         l_hold = ld_req && !e_gnt;
         phase_n = 0;
         if (cw) begin
            lastg = 1'b0;
            if (core_wr) mram[core_addr[7:0]] = core_wdata;
            else begin phase_n = 1; paddr = core_addr[7:0]; end
         end else if (lw) begin
            lastg = 1'b1;
            if (ld_we) mram[ld_addr[7:0]] = ld_wdata;
            else begin phase_n = 2; paddr = ld_addr[7:0]; end
         end
         phase = phase_n;
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_core_store();
      test_core_load();
      test_loader_read();
      test_contention();
      test_reset_inflight();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
